// File: rtl/top_selftest.sv
// Self-running datapath: free-running cycle counter, 16-bit Fibonacci LFSR and
// a four-state FSM that accumulates LFSR samples in fixed-length bursts.
// There are no functional outputs; all state is observed through the named
// internal registers (cycle_cnt, lfsr, acc, state, run_cnt, done_cnt, busy).
module top_selftest #(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] LFSR_SEED = 16'hACE1,
  parameter int               RUN_LEN   = 8
) (
  input logic clock,
  input logic reset
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
  localparam logic [7:0]       LAST_RUN = 8'(RUN_LEN - 1);

  // Fibonacci step with taps 16,14,13,11; a nonzero value never maps to zero.
  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] v);
    logic fb;
    fb = v[15] ^ v[13] ^ v[12] ^ v[10];
    return {v[WIDTH-2:0], fb};
  endfunction

  // Probe-visible registers
  logic [WIDTH-1:0] cycle_cnt;
  logic [WIDTH-1:0] lfsr;
  logic [WIDTH-1:0] acc;
  state_t           state;
  logic [7:0]       run_cnt;
  logic [7:0]       done_cnt;
  logic             busy;

  // Next-state values
  logic [WIDTH-1:0] cycle_cnt_nxt_s;
  logic [WIDTH-1:0] lfsr_nxt_s;
  logic [WIDTH-1:0] acc_nxt_s;
  state_t           state_nxt_s;
  logic [7:0]       run_cnt_nxt_s;
  logic [7:0]       done_cnt_nxt_s;
  logic             busy_nxt_s;

  // Next-state logic: counter and LFSR always advance, FSM drives the burst.
  always_comb begin
    cycle_cnt_nxt_s = cycle_cnt + ONE_W;
    lfsr_nxt_s      = lfsr_step(lfsr);
    acc_nxt_s       = acc;
    state_nxt_s     = state;
    run_cnt_nxt_s   = run_cnt;
    done_cnt_nxt_s  = done_cnt;
    busy_nxt_s      = busy;

    case (state)
      IDLE: begin
        state_nxt_s = LOAD;
      end
      LOAD: begin
        // Seed the sum with the pre-shift LFSR value.
        acc_nxt_s     = lfsr;
        run_cnt_nxt_s = 8'd0;
        busy_nxt_s    = 1'b1;
        state_nxt_s   = RUN;
      end
      RUN: begin
        acc_nxt_s     = acc + lfsr;
        run_cnt_nxt_s = run_cnt + 8'd1;
        if (run_cnt == LAST_RUN) begin
          // busy drops together with the move into DONE.
          busy_nxt_s  = 1'b0;
          state_nxt_s = DONE;
        end else begin
          busy_nxt_s  = 1'b1;
          state_nxt_s = RUN;
        end
      end
      DONE: begin
        busy_nxt_s = 1'b0;
        if (done_cnt != 8'hFF) begin
          done_cnt_nxt_s = done_cnt + 8'd1;
        end else begin
          done_cnt_nxt_s = done_cnt;
        end
        state_nxt_s = LOAD;
      end
      default: begin
        // Unreachable encodings behave like IDLE.
        state_nxt_s = LOAD;
      end
    endcase
  end

  // State registers with synchronous active-low reset taking priority.
  always_ff @(posedge clock) begin
    if (!reset) begin
      cycle_cnt <= ZERO_W;
      lfsr      <= LFSR_SEED;
      acc       <= ZERO_W;
      state     <= IDLE;
      run_cnt   <= 8'd0;
      done_cnt  <= 8'd0;
      busy      <= 1'b0;
    end else begin
      cycle_cnt <= cycle_cnt_nxt_s;
      lfsr      <= lfsr_nxt_s;
      acc       <= acc_nxt_s;
      state     <= state_nxt_s;
      run_cnt   <= run_cnt_nxt_s;
      done_cnt  <= done_cnt_nxt_s;
      busy      <= busy_nxt_s;
    end
  end

endmodule

// File: tb/tb_top_selftest.sv
// Scoreboard bench for top_selftest: the stimulus process drives reset and
// queues the expected register snapshot for each edge; the monitor pops one
// snapshot per edge and compares it with the probed internal registers.
module tb_top_selftest;

  typedef struct packed {
    logic [15:0] cyc;
    logic [15:0] lfsr;
    logic [15:0] acc;
    logic [1:0]  st;
    logic [7:0]  run;
    logic [7:0]  done;
    logic        busy;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;

  exp_t expq[$];
  exp_t model;
  exp_t trace[12];

  int n_checks = 0;
  int n_fail   = 0;

  top_selftest dut (
    .clock(clock),
    .reset(reset)
  );

  // Free-running clock, period 10.
  always #5 clock = ~clock;

  function automatic exp_t rst_exp();
    exp_t e;
    e.cyc  = 16'h0000;
    e.lfsr = 16'hACE1;
    e.acc  = 16'h0000;
    e.st   = 2'd0;
    e.run  = 8'd0;
    e.done = 8'd0;
    e.busy = 1'b0;
    return e;
  endfunction

  // Reference model of one rising edge.
  function automatic exp_t model_next(input exp_t c, input logic rst);
    exp_t n;
    logic fb;
    if (!rst) return rst_exp();
    n     = c;
    n.cyc = c.cyc + 16'd1;
    fb    = c.lfsr[15] ^ c.lfsr[13] ^ c.lfsr[12] ^ c.lfsr[10];
    n.lfsr = {c.lfsr[14:0], fb};
    case (c.st)
      2'd1: begin n.acc = c.lfsr; n.run = 8'd0; n.busy = 1'b1; n.st = 2'd2; end
      2'd2: begin
        n.acc = c.acc + c.lfsr;
        n.run = c.run + 8'd1;
        if (c.run == 8'd7) begin n.st = 2'd3; n.busy = 1'b0; end
      end
      2'd3: begin
        n.busy = 1'b0;
        n.done = (c.done == 8'hFF) ? 8'hFF : c.done + 8'd1;
        n.st   = 2'd1;
      end
      default: n.st = 2'd1;
    endcase
    return n;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // Monitor: one snapshot per edge, sampled 1 time unit after the edge.
  always @(posedge clock) begin
    exp_t e;
    #1;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      check("cycle_cnt", dut.cycle_cnt, e.cyc);
      check("lfsr",      dut.lfsr,      e.lfsr);
      check("acc",       dut.acc,       e.acc);
      check("state",     {14'd0, dut.state}, {14'd0, e.st});
      check("run_cnt",   {8'd0, dut.run_cnt},  {8'd0, e.run});
      check("done_cnt",  {8'd0, dut.done_cnt}, {8'd0, e.done});
      check("busy",      {15'd0, dut.busy},    {15'd0, e.busy});
      n_checks++;
      if (dut.lfsr == 16'h0000) begin
        n_fail++;
        $display("FAIL lfsr_nonzero: got %h expected nonzero at %0t", dut.lfsr, $time);
      end
    end
  end

  // Drive reset for the next edge away from the active edge and advance the model.
  task automatic drive(input logic rst);
    @(negedge clock);
    reset = rst;
    model = model_next(model, rst);
  endtask

  initial begin
    exp_t e;
    bit   found;
    model = rst_exp();

    // Three reset edges.
    for (int i = 0; i < 3; i++) begin
      drive(1'b0);
      expq.push_back(rst_exp());
    end

    // First burst after release with hand-computed checkpoints; record the trace.
    for (int i = 0; i < 12; i++) begin
      drive(1'b1);
      e = model;
      if (i == 0) begin e.cyc = 16'd1; e.lfsr = 16'h59C3; e.st = 2'd1; e.busy = 1'b0; end
      if (i == 1) begin e.st = 2'd2; e.acc = 16'h59C3; e.busy = 1'b1; e.lfsr = 16'hB387; end
      if (i == 2) begin e.acc = 16'h0D4A; e.run = 8'd1; e.lfsr = 16'h670F; e.cyc = 16'd3; end
      if (i == 9) begin e.st = 2'd3; e.busy = 1'b0; e.run = 8'd8; end
      if (i == 10) begin e.st = 2'd1; e.done = 8'd1; end
      trace[i] = e;
      expq.push_back(e);
    end

    // Advance until RUN with run_cnt == 4, then reset mid-burst.
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (model.st == 2'd2 && model.run == 8'd4) begin
        found = 1'b1;
        break;
      end
      drive(1'b1);
      expq.push_back(model);
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL midburst_reach: got no RUN/run_cnt=4 point expected one within 40 edges");
    end
    drive(1'b0);
    expq.push_back(rst_exp());

    // After re-release the first-burst trace must repeat exactly.
    for (int i = 0; i < 12; i++) begin
      drive(1'b1);
      expq.push_back(trace[i]);
    end

    // 300 bursts: done_cnt saturates.
    for (int i = 0; i < 3000; i++) begin
      drive(1'b1);
      e = model;
      if (i == 2999) e.done = 8'hFF;
      expq.push_back(e);
    end

    // Fresh reset, then 65536 edges: cycle_cnt wraps to zero.
    drive(1'b0);
    expq.push_back(rst_exp());
    for (int i = 0; i < 65536; i++) begin
      drive(1'b1);
      e = model;
      if (i == 65535) e.cyc = 16'h0000;
      expq.push_back(e);
    end

    // Let the monitor drain the queue.
    repeat (2) @(posedge clock);
    #2;
    n_checks++;
    if (expq.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: got %0d entries left expected 0", expq.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
